// File: rtl/vga_pkg.sv
// vga_pkg: shared sizes and state encoding for the glyph memory block.
//   GLYPH_ROWS   - number of 64-bit glyph rows (64 glyphs x 32 lines)
//   GLYPH_ADDR_W - row address width, {glyph code[5:0], glyph line[4:0]}
//   GLYPH_ROW_W  - row width, 32 pixels x 2 bits
//   glyph_mem_state_t - load/clear FSM states
package vga_pkg;

    localparam int GLYPH_ROWS   = 2048;
    localparam int GLYPH_ADDR_W = 11;
    localparam int GLYPH_ROW_W  = 64;

    // Last row index; LOAD and CLEAR leave when ptr reaches it.
    localparam logic [GLYPH_ADDR_W-1:0] GLYPH_PTR_LAST = GLYPH_ADDR_W'(GLYPH_ROWS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } glyph_mem_state_t;

endpackage

// File: rtl/glyph_ram.sv
// glyph_ram: 2048 x 64 synchronous RAM, one write port, one read port,
// read-first on a same-row collision. The read register is cleared by rst;
// the array itself is never touched by rst.
// Ports:
//   clk      - clock
//   rst      - synchronous active-high reset of the read register only
//   wr_en    - write strobe
//   wr_addr  - write row
//   wr_data  - write row data
//   rd_addr  - read row, sampled every cycle
//   rd_data  - registered read data (1-cycle latency)
module glyph_ram
    import vga_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [GLYPH_ADDR_W-1:0] wr_addr,
    input  logic [GLYPH_ROW_W-1:0]  wr_data,
    input  logic [GLYPH_ADDR_W-1:0] rd_addr,
    output logic [GLYPH_ROW_W-1:0]  rd_data
);

    logic [GLYPH_ROW_W-1:0] mem [GLYPH_ROWS];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Separate process with non-blocking read gives old data on collision.
    always_ff @(posedge clk) begin
        if (rst) rd_data <= '0;
        else     rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/glyph_mem.sv
// glyph_mem: glyph row store for the character-drawing stage, with a
// streaming byte loader and a full-memory clear.
// Optional feature: define GLYPH_MEM_CSUM_EN to add load_csum, the XOR of
// all bytes accepted by the current/most recent load.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   char_addr    - read row {glyph code, glyph line}
//   char_pixels  - registered row data, MSB pair is leftmost pixel
//   load_start   - pulse: start a 16384-byte load (IDLE only)
//   clear_start  - pulse: start a full clear (IDLE only, wins over load)
//   load_data    - load byte stream
//   load_valid   - load_data valid
//   load_ready   - byte accepted when load_valid && load_ready
//   busy         - high in CLEAR and LOAD
//   load_done    - one-cycle pulse when a load or clear finishes
//   load_csum    - (GLYPH_MEM_CSUM_EN) XOR of accepted load bytes
module glyph_mem
    import vga_pkg::*;
#(
    parameter logic [GLYPH_ROW_W-1:0] CLEAR_WORD = 64'h0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [GLYPH_ADDR_W-1:0] char_addr,
    output logic [GLYPH_ROW_W-1:0]  char_pixels,
    input  logic                    load_start,
    input  logic                    clear_start,
    input  logic [7:0]              load_data,
    input  logic                    load_valid,
    output logic                    load_ready,
    output logic                    busy,
    output logic                    load_done
`ifdef GLYPH_MEM_CSUM_EN
    ,
    output logic [7:0]              load_csum
`endif
);

    glyph_mem_state_t        state, next_state;
    logic [GLYPH_ADDR_W-1:0] ptr;
    logic [2:0]              byte_cnt;
    logic [55:0]             row_acc;   // bytes 0..6 of the row being built
    logic                    accept;
    logic                    wr_en;
    logic [GLYPH_ROW_W-1:0]  wr_data;

    assign accept = (state == LOAD) && load_valid;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        wr_en      = 1'b0;
        wr_data    = CLEAR_WORD;
        load_ready = 1'b0;
        busy       = 1'b0;
        load_done  = 1'b0;
        case (state)
            IDLE: begin
                if (clear_start)     next_state = CLEAR;
                else if (load_start) next_state = LOAD;
            end
            CLEAR: begin
                busy  = 1'b1;
                wr_en = 1'b1;
                if (ptr == GLYPH_PTR_LAST) next_state = DONE;
            end
            LOAD: begin
                busy       = 1'b1;
                load_ready = 1'b1;
                // Byte 7 goes straight into the write, no extra cycle.
                wr_data    = {row_acc, load_data};
                if (accept && byte_cnt == 3'd7) begin
                    wr_en = 1'b1;
                    if (ptr == GLYPH_PTR_LAST) next_state = DONE;
                end
            end
            DONE: begin
                load_done  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Counters idle at zero, so entry to LOAD/CLEAR always starts at row 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            byte_cnt <= '0;
            row_acc  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ptr      <= '0;
                    byte_cnt <= '0;
                end
                CLEAR: ptr <= ptr + 11'd1;
                LOAD: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 3'd1;
                        row_acc  <= {row_acc[47:0], load_data};
                        if (byte_cnt == 3'd7) ptr <= ptr + 11'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef GLYPH_MEM_CSUM_EN
    always_ff @(posedge clk) begin
        if (rst)                                        load_csum <= '0;
        else if (state == IDLE && next_state == LOAD)   load_csum <= '0;
        else if (accept)                                load_csum <= load_csum ^ load_data;
    end
`endif

    // A write coinciding with rst is dropped so an abort never lands a row.
    glyph_ram u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en && !rst),
        .wr_addr (ptr),
        .wr_data (wr_data),
        .rd_addr (char_addr),
        .rd_data (char_pixels)
    );

endmodule

// File: tb/tb_glyph_mem.sv
module tb_glyph_mem;

    localparam logic [63:0] CW = 64'hFFFF_0000_FFFF_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] char_addr;
    logic [63:0] char_pixels;
    logic        load_start, clear_start;
    logic [7:0]  load_data;
    logic        load_valid;
    logic        load_ready, busy, load_done;
`ifdef GLYPH_MEM_CSUM_EN
    logic [7:0]  load_csum;
`endif

    int total = 0;
    int fails = 0;

    always #5 clk = ~clk;

    glyph_mem #(.CLEAR_WORD(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .char_addr   (char_addr),
        .char_pixels (char_pixels),
        .load_start  (load_start),
        .clear_start (clear_start),
        .load_data   (load_data),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .busy        (busy),
        .load_done   (load_done)
`ifdef GLYPH_MEM_CSUM_EN
        ,
        .load_csum   (load_csum)
`endif
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // mode 0: row 0 = 01..08, row 1 byte 0 = AD, rest 0 (XOR of all = A5)
    // mode 1: every byte 5A
    function automatic logic [7:0] byte_of(input int mode, input int i);
        if (mode == 1) return 8'h5A;
        if (i < 8)     return 8'(i + 1);
        if (i == 8)    return 8'hAD;
        return 8'h00;
    endfunction

    task automatic rd(input string tag, input logic [10:0] a, input logic [63:0] exp);
        char_addr = a;
        step;
        chk(tag, char_pixels, exp);
    endtask

    task automatic do_clear(input bit collide);
        int busy_n = 0, done_n = 0, rdy_n = 0;
        clear_start = 1'b1;
        load_start  = collide;
        step;
        clear_start = 1'b0;
        for (int c = 0; c < 2100; c++) begin
            load_start = collide && (c < 10);
            if (busy)       busy_n++;
            if (load_done)  done_n++;
            if (load_ready) rdy_n++;
            step;
        end
        load_start = 1'b0;
        chk("clear_busy_cycles", 64'(busy_n), 64'd2048);
        chk("clear_done_pulses", 64'(done_n), 64'd1);
        chk("clear_ready_seen",  64'(rdy_n),  64'd0);
    endtask

    task automatic do_load(input int mode, input bit toggle, input int nbytes);
        load_start = 1'b1;
        step;
        load_start = 1'b0;
        chk("load_busy", {63'd0, busy}, 64'd1);
        for (int i = 0; i < nbytes; i++) begin
            if (toggle) begin
                load_valid = 1'b0;
                load_data  = 8'hEE;
                step;
            end
            load_valid = 1'b1;
            load_data  = byte_of(mode, i);
            if (nbytes == 16384 && i == nbytes - 1) begin
                chk("load_no_early_done", {63'd0, load_done}, 64'd0);
                chk("load_ready_last",    {63'd0, load_ready}, 64'd1);
            end
            step;
        end
        load_valid = 1'b0;
        if (nbytes == 16384) begin
            chk("load_done_pulse", {63'd0, load_done}, 64'd1);
            chk("load_busy_done",  {63'd0, busy}, 64'd0);
`ifdef GLYPH_MEM_CSUM_EN
            chk("csum_at_done", 64'(load_csum), 64'hA5);
`endif
            step;
            chk("load_done_one_cycle", {63'd0, load_done}, 64'd0);
        end
    endtask

    initial begin
        rst = 1'b1; char_addr = '0; load_start = 1'b0; clear_start = 1'b0;
        load_data = '0; load_valid = 1'b0;
        step; step;
        chk("rst_pixels", char_pixels, 64'd0);
        chk("rst_busy",   {63'd0, busy}, 64'd0);
        chk("rst_ready",  {63'd0, load_ready}, 64'd0);
        chk("rst_done",   {63'd0, load_done}, 64'd0);
        rst = 1'b0;
        step;

        // Clear with simultaneous load_start, then load_start during CLEAR.
        do_clear(1'b1);
        rd("clear_row_7ff", 11'h7FF, CW);
        rd("clear_row_000", 11'h000, CW);

        // Continuous load.
        do_load(0, 1'b0, 16384);
        rd("load_row0", 11'd0, 64'h0102030405060708);
        rd("load_row1", 11'd1, 64'hAD00_0000_0000_0000);
        rd("load_row2", 11'd2, 64'd0);
        rd("load_row_7ff", 11'h7FF, 64'd0);

        // Clear must not disturb the checksum.
        do_clear(1'b0);
`ifdef GLYPH_MEM_CSUM_EN
        chk("csum_after_clear", 64'(load_csum), 64'hA5);
`endif
        rd("clear2_row0", 11'd0, CW);

        // Same data with load_valid toggling every cycle.
        do_load(0, 1'b1, 16384);
        rd("tog_row0", 11'd0, 64'h0102030405060708);
        rd("tog_row1", 11'd1, 64'hAD00_0000_0000_0000);
        rd("tog_row2", 11'd2, 64'd0);
        rd("tog_row_7ff", 11'h7FF, 64'd0);

        // Reset after 1000 rows plus three bytes of row 1000.
        do_clear(1'b0);
        char_addr = 11'd0;
        do_load(1, 1'b0, 8003);
        rst = 1'b1;
        step;
        chk("abort_pixels", char_pixels, 64'd0);
        chk("abort_busy",   {63'd0, busy}, 64'd0);
        chk("abort_ready",  {63'd0, load_ready}, 64'd0);
`ifdef GLYPH_MEM_CSUM_EN
        chk("abort_csum", 64'(load_csum), 64'd0);
`endif
        rst = 1'b0;
        rd("abort_row0",    11'd0,    64'h5A5A_5A5A_5A5A_5A5A);
        rd("abort_row999",  11'd999,  64'h5A5A_5A5A_5A5A_5A5A);
        rd("abort_row1000", 11'd1000, CW);
        rd("abort_row1001", 11'd1001, CW);
        rd("abort_row_7ff", 11'h7FF,  CW);
        chk("abort_idle_busy", {63'd0, busy}, 64'd0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/glyph_mem.md
GLYPH_MEM -- requirements
Module: glyph_mem

Interface
REQ-001 The module SHALL have parameter CLEAR_WORD, default 64'h0: the word written to every row during a clear.
REQ-002 The module SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port char_addr, input, 11 bits: read address {glyph code[5:0], glyph line[4:0]}, driven by the character-drawing stage.
REQ-005 The module SHALL have port char_pixels, output, 64 bits: registered row data, 32 pixels x 2 bits, MSB pair leftmost.
REQ-006 The module SHALL have port load_start, input, 1 bit: a one-cycle pulse that begins a full glyph load.
REQ-007 The module SHALL have port clear_start, input, 1 bit: a one-cycle pulse that begins a full clear.
REQ-008 The module SHALL have port load_data, input, 8 bits: the load byte stream.
REQ-009 The module SHALL have port load_valid, input, 1 bit: load_data is valid.
REQ-010 The module SHALL have port load_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-011 The module SHALL have port busy, output, 1 bit: high while in CLEAR or LOAD.
REQ-012 The module SHALL have port load_done, output, 1 bit: a one-cycle pulse when a load or clear completes.

Function
REQ-013 Storage SHALL be 2048 rows x 64 bits, with row index equal to char_addr.
REQ-014 Read latency SHALL be 1 cycle: char_addr sampled at edge N appears on char_pixels after edge N, and reads run continuously in every state.
REQ-015 A read and a write to the same row in the same cycle SHALL return the old data (read-first).
REQ-016 The FSM SHALL have states IDLE, CLEAR, LOAD and DONE.
REQ-017 In IDLE, clear_start SHALL go to CLEAR; otherwise load_start SHALL go to LOAD; clear_start wins when both are asserted.
REQ-018 load_start and clear_start SHALL be ignored outside IDLE.
REQ-019 CLEAR SHALL write CLEAR_WORD to row ptr every cycle, ptr 0..2047, then go to DONE; clearing takes 2048 cycles.
REQ-020 In LOAD, load_ready SHALL be 1 and a byte SHALL be accepted when load_valid && load_ready.
REQ-021 A 3-bit byte counter SHALL assemble each row: byte 0 goes to bits [63:56] and byte 7 to bits [7:0].
REQ-022 On acceptance of byte 7, the assembled row SHALL be written to row ptr in that same cycle, and ptr SHALL increment.
REQ-023 After row 2047 is written, the FSM SHALL go to DONE, so a load is 16384 bytes.
REQ-024 load_valid low in LOAD SHALL stall with no state change and no timeout.
REQ-025 DONE SHALL last exactly 1 cycle, assert load_done, and then go to IDLE.
REQ-026 load_ready SHALL be 0 in IDLE, CLEAR and DONE.
REQ-027 ptr SHALL be 11 bits and SHALL NOT wrap within an operation; the transition out of LOAD or CLEAR occurs at ptr = 2047.
REQ-028 ptr and the byte counter SHALL be zeroed on entry to LOAD or CLEAR.

Reset
REQ-029 On rst, the FSM SHALL go to IDLE, ptr and the byte counter SHALL be 0, char_pixels SHALL be 0, and load_ready, busy and load_done SHALL be 0.
REQ-030 Memory contents SHALL NOT be altered by rst.
REQ-031 An rst asserted mid-LOAD or mid-CLEAR SHALL abort the operation, leave rows already written intact, and discard a partially assembled row.
REQ-032 The first read after rst is released SHALL return valid data one cycle later.

Configuration
REQ-033 With macro GLYPH_MEM_CSUM_EN defined, the module SHALL add output load_csum, 8 bits.
REQ-034 load_csum SHALL be the XOR of all bytes accepted in the current load, cleared to 0 on entry to LOAD and on rst.
REQ-035 load_csum SHALL be stable from the DONE cycle until the next LOAD entry, and SHALL be unaffected by CLEAR.
REQ-036 Without GLYPH_MEM_CSUM_EN, the load_csum port and its logic SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-037 vga_pkg SHALL hold GLYPH_ROWS (2048), GLYPH_ADDR_W (11), GLYPH_ROW_W (64) and the FSM state enum glyph_mem_state_t.
REQ-038 One sub-module, glyph_ram, SHALL implement the 2048x64 single-write, single-read, read-first synchronous RAM, and SHALL be inferable as block RAM.
REQ-039 The FSM, byte assembly and checksum logic SHALL reside in glyph_mem.

Verification
REQ-040 The bench SHALL cover: after rst, pulse clear_start with CLEAR_WORD=64'hFFFF_0000_FFFF_0000 -> busy high for 2048 cycles, load_done pulses once, and a read of addr 11'h7FF returns 64'hFFFF_0000_FFFF_0000.
REQ-041 The bench SHALL cover: load_start, then bytes 01..08 for row 0 and zeros for the rest -> char_addr 0 returns 64'h0102030405060708 one cycle after it is applied, and load_done pulses after the 16384th byte.
REQ-042 The bench SHALL cover: load_valid toggling 1/0 every cycle during LOAD -> 16384 accepts, data identical to the continuous case, and no dropped or duplicated bytes.
REQ-043 The bench SHALL cover: clear_start and load_start in the same cycle -> CLEAR is entered; load_start during CLEAR -> ignored, and load_ready stays 0.
REQ-044 The bench SHALL cover: rst after 1000 rows of a load -> rows 0..999 hold the loaded data, rows 1000+ are unchanged, busy is 0, and char_pixels is 0 on the cycle after rst.
REQ-045 The bench SHALL cover, with GLYPH_MEM_CSUM_EN: a load of bytes whose XOR is 8'hA5 -> load_csum = 8'hA5 at load_done, held through a subsequent CLEAR.
